// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, DEPTH-entry {pc, instr} queue to decode.
// Optional IF_NOP_FILL_EN: present addi x0,x0,0 on out_instr whenever out_valid is low.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
`ifdef IF_NOP_FILL_EN
  localparam logic [31:0]     FILL_INSTR = 32'h0000_0013;
`else
  localparam logic [31:0]     FILL_INSTR = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DISCARD} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc, w_fetch_pc_next;
  logic [31:0]   r_old_addr, w_old_addr_next;
  logic [31:0]   r_q_pc    [DEPTH];
  logic [31:0]   r_q_instr [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_next;
  logic          w_push, w_pop;
  logic [31:0]   w_redirect_target;

  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_old_addr_next = r_old_addr;
    imem_req        = 1'b0;
    imem_addr       = r_fetch_pc;
    w_push          = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        imem_req = (r_count < CNT_FULL);
        if (imem_req) begin
          if (imem_ack) begin
            w_push          = 1'b1;
            w_fetch_pc_next = r_fetch_pc + 32'd4;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
          w_state_next    = S_FETCH;
        end
      end
      S_DISCARD: begin
        // Old-path request still in flight: keep presenting it, drop its data.
        imem_req  = 1'b1;
        imem_addr = r_old_addr;
        if (imem_ack) w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (redirect_valid) begin
      w_push          = 1'b0;
      w_fetch_pc_next = w_redirect_target;
      if (imem_req && !imem_ack) begin
        w_state_next    = S_DISCARD;
        w_old_addr_next = imem_addr;
      end else begin
        w_state_next = S_FETCH;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready && !redirect_valid;

  always_comb begin
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    if (redirect_valid) w_count_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_old_addr <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_old_addr <= w_old_addr_next;
      r_count    <= w_count_next;
      if (redirect_valid) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_fetch_pc;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  assign out_pc    = out_valid ? r_q_pc[r_rd_ptr]    : 32'h0000_0000;
  assign out_instr = out_valid ? r_q_instr[r_rd_ptr] : FILL_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage: the bench plays instruction memory
// and predicts the delivered stream as consecutive PCs per path, restarting on redirects.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] MAGIC    = 32'hA5A5_0000;
`ifdef IF_NOP_FILL_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
`else
  localparam logic [31:0] NOP = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          wait_cnt;
  logic [31:0] model_pc, last_addr, cur_addr, cur_tgt;
  logic        stale, outstanding, idle, cur_r, cur_a, cur_d;
  logic        done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0103;
      1:       return 32'h0000_0100;
      2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom & 32'h0000_FFFF;
    endcase
  endfunction

  // Apply the effect of the edge just passed to the expected stream.
  task automatic commit_edge();
    entry_t e;
    idle      = 1'b0;
    last_addr = cur_addr;
    if (cur_d) begin
      sb.delete();
      model_pc = {cur_tgt[31:2], 2'b00};
      stale    = cur_r && !cur_a;
    end else if (cur_r && cur_a) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        e.pc    = model_pc;
        e.instr = model_pc ^ MAGIC;
        sb.push_back(e);
        model_pc = model_pc + 32'd4;
      end
    end
    outstanding = cur_r && !cur_a;
  endtask

  task automatic cycle(input int lat, input int rdy_pct, input int rd_pct,
                       input logic frc, input logic [31:0] ftgt);
    logic r, a, d;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    commit_edge();
    r = imem_req;
    a = 1'b0;
    if (r) begin
      if (wait_cnt >= lat) begin
        a = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    d   = frc || ($urandom_range(0, 99) < rd_pct);
    tgt = frc ? ftgt : pick_target();
    imem_ack       = a;
    // Junk always has low bits 11, so it can never look like a real word.
    imem_rdata     = (a && !stale) ? (imem_addr ^ MAGIC) : ($urandom | 32'h0000_0003);
    redirect_valid = d;
    redirect_pc    = tgt;
    out_ready      = ($urandom_range(0, 99) < rdy_pct);
    cur_r = r; cur_a = a; cur_d = d; cur_tgt = tgt; cur_addr = imem_addr;
  endtask

  task automatic do_release(input logic late_ack);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    model_pc = RESET_PC; last_addr = RESET_PC;
    stale = 1'b0; outstanding = 1'b0; idle = 1'b1;
    cur_r = 1'b0; cur_a = 1'b0; cur_d = 1'b0; cur_addr = RESET_PC; cur_tgt = '0;
    wait_cnt = 0;
    imem_ack = late_ack; imem_rdata = 32'hDEAD_0003;
    redirect_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic mid_reset();
    #3 rst_n = 1'b0;
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1 imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_0003;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    do_release(1'b1);
  endtask

  // Monitor: samples mid-cycle, checks handshake rules and pops on consumption.
  initial begin
    entry_t h;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (!rst_n) begin
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, NOP);
      end else begin
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (!out_valid) begin
          check("bubble_pc", out_pc, 32'd0);
          check("bubble_instr", out_instr, NOP);
        end
        if (idle) begin
          check("idle_req", 32'(imem_req), 32'd0);
          check("idle_addr", imem_addr, RESET_PC);
        end else if (outstanding) begin
          check("hold_req", 32'(imem_req), 32'd1);
          check("hold_addr", imem_addr, last_addr);
        end else begin
          check("req", 32'(imem_req), 32'(sb.size() < DEPTH));
          if (imem_req) check("addr", imem_addr, model_pc);
        end
        if (out_valid && sb.size() != 0) begin
          h = sb[0];
          check("head_pc", out_pc, h.pc);
          check("head_instr", out_instr, h.instr);
          if (out_ready && !redirect_valid) begin
            void'(sb.pop_front());
            $display("[TB] pop pc=%08h instr=%08h t=%0t", out_pc, out_instr, $time);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    sb.delete(); model_pc = RESET_PC; last_addr = RESET_PC;
    stale = 1'b0; outstanding = 1'b0; idle = 1'b1;
    cur_r = 1'b0; cur_a = 1'b0; cur_d = 1'b0; cur_addr = '0; cur_tgt = '0; wait_cnt = 0;
    repeat (3) @(posedge clk);
    do_release(1'b0);
    repeat (40) cycle(0, 100, 0, 1'b0, 32'h0);           // zero-wait streaming
    repeat (60) cycle(3, 100, 0, 1'b0, 32'h0);           // 3-cycle latency
    repeat (10) cycle(0, 0, 0, 1'b0, 32'h0);             // decode stalled
    repeat (20) cycle(0, 100, 0, 1'b0, 32'h0);
    repeat (5)  cycle(3, 100, 0, 1'b0, 32'h0);
    cycle(3, 100, 0, 1'b1, 32'h0000_0100);               // redirect while waiting
    repeat (10) cycle(2, 100, 0, 1'b0, 32'h0);
    repeat (5)  cycle(0, 0, 0, 1'b0, 32'h0);
    cycle(0, 100, 0, 1'b1, 32'h0000_0103);               // redirect with unaligned target
    repeat (10) cycle(0, 100, 0, 1'b0, 32'h0);
    mid_reset();
    repeat (20) cycle(0, 100, 0, 1'b0, 32'h0);
    repeat (1500) cycle(int'($urandom_range(0, 3)), 70, 5, 1'b0, 32'h0);
    cycle(0, 100, 0, 1'b1, 32'hFFFF_FFF6);               // run across the PC wrap
    repeat (12) cycle(0, 100, 0, 1'b0, 32'h0);
    repeat (10) cycle(1, 100, 0, 1'b0, 32'h0);
    @(posedge clk);
    #1 done = 1'b1;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
